// File: rtl/dht11_uart_formatter.sv
// Formats one latched DHT11 reading as "H=hh.d T=tt.d\r\n" and streams it byte-wise to a UART transmitter.
// Optional CHECKSUM_EN: a bad checksum sends "ERR\r\n" instead of the reading.
module dht11_uart_formatter #(
  parameter int REQ_TIMEOUT = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_valid,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic [7:0] checksum,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_LOAD, S_REQ, S_WAIT} state_t;

  state_t                 r_state, w_next;
  logic [6:0]             r_h_rem, r_t_rem;
  logic [3:0]             r_h_tens, r_t_tens, r_hd, r_td;
  logic [3:0]             r_idx;
  logic [TIMEOUT_W-1:0]   r_to;
  logic [7:0]             r_tx_data;
  logic                   r_done, r_err, r_cs_bad;
  logic                   w_cs_bad, w_last, w_conv_done, w_to_hit;
  logic [7:0]             w_byte;

  function automatic logic [6:0] clamp_int(input logic [7:0] v);
    clamp_int = (v > 8'd99) ? 7'd99 : v[6:0];
  endfunction

  function automatic logic [3:0] clamp_dec(input logic [7:0] v);
    clamp_dec = (v > 8'd9) ? 4'd9 : v[3:0];
  endfunction

  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic err,
                                            input logic [3:0] ht, input logic [3:0] hu,
                                            input logic [3:0] hd, input logic [3:0] tt,
                                            input logic [3:0] tu, input logic [3:0] td);
    frame_byte = 8'h00;
    if (err) begin
      case (idx)
        4'd0:       frame_byte = 8'h45;
        4'd1, 4'd2: frame_byte = 8'h52;
        4'd3:       frame_byte = 8'h0D;
        4'd4:       frame_byte = 8'h0A;
        default:    frame_byte = 8'h00;
      endcase
    end else begin
      case (idx)
        4'd0:    frame_byte = 8'h48;
        4'd1:    frame_byte = 8'h3D;
        4'd2:    frame_byte = {4'h3, ht};
        4'd3:    frame_byte = {4'h3, hu};
        4'd4:    frame_byte = 8'h2E;
        4'd5:    frame_byte = {4'h3, hd};
        4'd6:    frame_byte = 8'h20;
        4'd7:    frame_byte = 8'h54;
        4'd8:    frame_byte = 8'h3D;
        4'd9:    frame_byte = {4'h3, tt};
        4'd10:   frame_byte = {4'h3, tu};
        4'd11:   frame_byte = 8'h2E;
        4'd12:   frame_byte = {4'h3, td};
        4'd13:   frame_byte = 8'h0D;
        4'd14:   frame_byte = 8'h0A;
        default: frame_byte = 8'h00;
      endcase
    end
  endfunction

`ifdef CHECKSUM_EN
  logic [7:0] w_sum;
  assign w_sum    = hum_int + hum_dec + temp_int + temp_dec;
  assign w_cs_bad = (w_sum != checksum);
`else
  logic w_unused_cs;
  assign w_unused_cs = ^checksum;
  assign w_cs_bad    = 1'b0;
`endif

  // After CONV the remainders hold the units digits.
  assign w_byte      = frame_byte(r_idx, r_cs_bad, r_h_tens, r_h_rem[3:0], r_hd,
                                  r_t_tens, r_t_rem[3:0], r_td);
  assign w_last      = r_cs_bad ? (r_idx == 4'd4) : (r_idx == 4'd14);
  assign w_conv_done = (r_h_rem < 7'd10) && (r_t_rem < 7'd10);
  assign w_to_hit    = (r_to == TIMEOUT_W'(REQ_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (sample_valid) w_next = S_CONV;
      S_CONV: if (w_conv_done) w_next = S_LOAD;
      S_LOAD: w_next = S_REQ;
      S_REQ: begin
        if (tx_busy)       w_next = S_WAIT;
        else if (w_to_hit) w_next = S_IDLE;
      end
      S_WAIT: if (!tx_busy) w_next = w_last ? S_IDLE : S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_rem   <= '0;
      r_t_rem   <= '0;
      r_h_tens  <= '0;
      r_t_tens  <= '0;
      r_hd      <= '0;
      r_td      <= '0;
      r_idx     <= '0;
      r_to      <= '0;
      r_tx_data <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_cs_bad  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (sample_valid) begin
          r_h_rem  <= clamp_int(hum_int);
          r_t_rem  <= clamp_int(temp_int);
          r_hd     <= clamp_dec(hum_dec);
          r_td     <= clamp_dec(temp_dec);
          r_h_tens <= '0;
          r_t_tens <= '0;
          r_idx    <= '0;
          r_cs_bad <= w_cs_bad;
        end
        S_CONV: begin
          if (r_h_rem >= 7'd10) begin
            r_h_rem  <= r_h_rem - 7'd10;
            r_h_tens <= r_h_tens + 4'd1;
          end
          if (r_t_rem >= 7'd10) begin
            r_t_rem  <= r_t_rem - 7'd10;
            r_t_tens <= r_t_tens + 4'd1;
          end
        end
        S_LOAD: begin
          r_tx_data <= w_byte;
          r_to      <= '0;
        end
        S_REQ: if (!tx_busy) begin
          r_to <= r_to + TIMEOUT_W'(1);
          if (w_to_hit) r_err <= 1'b1;
        end
        S_WAIT: if (!tx_busy) begin
          if (w_last) r_done <= 1'b1;
          else        r_idx  <= r_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign tx_start   = (r_state == S_REQ);
  assign busy       = (r_state != S_IDLE);
  assign tx_data    = r_tx_data;
  assign frame_done = r_done;
  assign frame_err  = r_err;

endmodule

// File: tb/tb_dht11_uart_formatter.sv
// Bench for dht11_uart_formatter: table vectors, random readings against a string-level model,
// and hand-written sequences for timeout, ignored resample and mid-frame reset.
module tb_dht11_uart_formatter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_valid;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec, checksum;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy, frame_done, frame_err;

  dht11_uart_formatter #(.REQ_TIMEOUT(255), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
    .checksum(checksum), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

`ifdef CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_err   = 0;
  logic [7:0] cap[$];
  bit xmit_en = 1'b1;
  bit rnd_tx  = 1'b0;

  typedef struct {
    logic [7:0] hi, hd, ti, td;
    string      exp;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic string model(input logic [7:0] hi, input logic [7:0] hd,
                                  input logic [7:0] ti, input logic [7:0] td,
                                  input logic [7:0] cs);
    int h, hdv, t, tdv;
    if (CS_EN && (8'(hi + hd + ti + td) != cs)) return "ERR\r\n";
    h   = (hi > 99) ? 99 : int'(hi);
    hdv = (hd > 9)  ? 9  : int'(hd);
    t   = (ti > 99) ? 99 : int'(ti);
    tdv = (td > 9)  ? 9  : int'(td);
    return $sformatf("H=%02d.%0d T=%02d.%0d\r\n", h, hdv, t, tdv);
  endfunction

  // Transmitter model: samples tx_data on tx_start rise, busy starts gap cycles later.
  initial begin
    bit prev = 1'b0;
    int m_wait = 0, m_len = 0, gap, blen;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        tx_busy = 1'b0; m_wait = 0; m_len = 0; prev = 1'b0;
      end else begin
        if (m_len > 0) begin
          m_len--;
          if (m_len == 0) tx_busy = 1'b0;
        end else if (m_wait > 0) begin
          m_wait--;
          if (m_wait == 0) begin tx_busy = 1'b1; m_len = blen; end
        end
        if (tx_start && !prev && xmit_en) begin
          cap.push_back(tx_data);
          gap  = rnd_tx ? int'($urandom_range(1, 3))  : 2;
          blen = rnd_tx ? int'($urandom_range(1, 20)) : 20;
          m_wait = gap;
        end
        prev = tx_start;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (frame_done) n_done++;
      if (frame_err)  n_err++;
    end
  end

  task automatic drive(input logic [7:0] hi, input logic [7:0] hd, input logic [7:0] ti,
                       input logic [7:0] td, input logic [7:0] cs);
    @(posedge clk); #1;
    hum_int = hi; hum_dec = hd; temp_int = ti; temp_dec = td; checksum = cs;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_end(input string nm, input int d0, input int e0);
    bit got = 1'b0;
    for (int k = 0; k < 8000; k++) begin
      @(negedge clk);
      if (n_done != d0 || n_err != e0) begin got = 1'b1; break; end
    end
    chk({nm, "_complete"}, int'(got), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string nm, input string exp, input int d0, input int e0);
    chk({nm, "_len"}, cap.size(), exp.len());
    for (int i = 0; i < exp.len() && i < cap.size(); i++)
      chk($sformatf("%s_b%0d", nm, i), int'(cap[i]), int'(exp[i]));
    chk({nm, "_done_cnt"}, n_done - d0, 1);
    chk({nm, "_err_cnt"}, n_err - e0, 0);
    chk({nm, "_busy"}, int'(busy), 0);
  endtask

  task automatic run_frame(input logic [7:0] hi, input logic [7:0] hd, input logic [7:0] ti,
                           input logic [7:0] td, input logic [7:0] cs,
                           input string exp, input string nm);
    int d0, e0, c;
    cap.delete();
    d0 = n_done; e0 = n_err;
    drive(hi, hd, ti, td, cs);
    c = 1;
    while (!tx_start && c < 20) begin @(posedge clk); #1; c++; end
    chk({nm, "_latency_le12"}, int'(c <= 12), 1);
    wait_end(nm, d0, e0);
    check_frame(nm, exp, d0, e0);
  endtask

  initial begin
    int d0, e0, len, c;
    logic [7:0] hi, hd, ti, td, cs;
    rst_n = 1'b0; sample_valid = 1'b0;
    hum_int = 0; hum_dec = 0; temp_int = 0; temp_dec = 0; checksum = 0;

    tbl[0] = '{8'd45,  8'd0,  8'd23,  8'd0,   "H=45.0 T=23.0\r\n"};
    tbl[1] = '{8'd150, 8'd12, 8'd7,   8'd3,   "H=99.9 T=07.3\r\n"};
    tbl[2] = '{8'd0,   8'd0,  8'd0,   8'd0,   "H=00.0 T=00.0\r\n"};
    tbl[3] = '{8'd99,  8'd9,  8'd99,  8'd9,   "H=99.9 T=99.9\r\n"};
    tbl[4] = '{8'd100, 8'd10, 8'd255, 8'd255, "H=99.9 T=99.9\r\n"};
    tbl[5] = '{8'd10,  8'd9,  8'd9,   8'd10,  "H=10.9 T=09.9\r\n"};

    repeat (2) @(posedge clk); #1;
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_frame(tbl[i].hi, tbl[i].hd, tbl[i].ti, tbl[i].td,
                8'(tbl[i].hi + tbl[i].hd + tbl[i].ti + tbl[i].td),
                tbl[i].exp, $sformatf("tbl%0d", i));

    rnd_tx = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hi = 8'($urandom_range(0, 255)); hd = 8'($urandom_range(0, 15));
      ti = 8'($urandom_range(0, 120)); td = 8'($urandom_range(0, 12));
      cs = ($urandom_range(0, 1) == 0) ? 8'(hi + hd + ti + td) : 8'($urandom);
      run_frame(hi, hd, ti, td, cs, model(hi, hd, ti, td, cs), $sformatf("rnd%0d", i));
    end
    rnd_tx = 1'b0;

    // Second sample during byte 5 must be ignored.
    cap.delete(); d0 = n_done; e0 = n_err;
    drive(8'd12, 8'd3, 8'd56, 8'd7, 8'd78);
    c = 0;
    while (cap.size() < 5 && c < 3000) begin @(posedge clk); #1; c++; end
    chk("resample_reach_b5", int'(cap.size() >= 5), 1);
    drive(8'd88, 8'd1, 8'd33, 8'd2, 8'd124);
    wait_end("resample", d0, e0);
    check_frame("resample", "H=12.3 T=56.7\r\n", d0, e0);
    repeat (100) @(negedge clk);
    chk("resample_no_second_frame", cap.size(), 15);
    chk("resample_busy_after", int'(busy), 0);

    // Transmitter never accepts: request times out.
    xmit_en = 1'b0; cap.delete(); d0 = n_done; e0 = n_err;
    drive(8'd45, 8'd0, 8'd23, 8'd0, 8'd68);
    c = 1;
    while (!tx_start && c < 20) begin @(posedge clk); #1; c++; end
    len = 0;
    while (tx_start && len < 1000) begin @(posedge clk); #1; len++; end
    chk("timeout_start_len", len, 255);
    repeat (3) @(negedge clk);
    chk("timeout_err_cnt", n_err - e0, 1);
    chk("timeout_done_cnt", n_done - d0, 0);
    chk("timeout_busy", int'(busy), 0);
    xmit_en = 1'b1;

    // Asynchronous reset during byte 8's WAIT, then a clean frame.
    cap.delete(); d0 = n_done;
    drive(8'd45, 8'd0, 8'd23, 8'd0, 8'd68);
    c = 0;
    while (!(cap.size() >= 9 && tx_busy && !tx_start) && c < 3000) begin
      @(posedge clk); #2; c++;
    end
    chk("mrst_reach_b8_wait", int'(c < 3000), 1);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("mrst_tx_start", int'(tx_start), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_tx_data", int'(tx_data), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("mrst_no_done", n_done - d0, 0);
    run_frame(8'd31, 8'd4, 8'd19, 8'd8, 8'd62, "H=31.4 T=19.8\r\n", "post_rst");

`ifdef CHECKSUM_EN
    run_frame(8'd40, 8'd0, 8'd25, 8'd0, 8'd65, "H=40.0 T=25.0\r\n", "cs_ok");
    run_frame(8'd40, 8'd0, 8'd25, 8'd0, 8'd0, "ERR\r\n", "cs_bad");
`else
    run_frame(8'd40, 8'd0, 8'd25, 8'd0, 8'd0, "H=40.0 T=25.0\r\n", "cs_ignored");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
